// File: rtl/flt2fix_arb.sv
// flt2fix_arb: round-robin arbiter feeding one shared float-to-index converter.
// Optional FLT2FIX_ARB_NEG_EN adds out_neg (operand sign captured with the result).
module flt2fix_arb #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_flt,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          cvt_flt,
  input  logic [6:0]           cvt_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           out_idx,
  output logic [IDW-1:0]       out_id
`ifdef FLT2FIX_ARB_NEG_EN
  ,
  output logic                 out_neg
`endif
);
  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] p, win, scan, id;
  logic [31:0] op;
  logic grant;
  // scan downwards so the lowest offset from the pointer wins
  always_comb begin
    win = '0;
    scan = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = IDW'((int'(p) + k) % NREQ);
      if (req_valid[scan]) win = scan;
    end
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == CONV) ? OUT :
               (state == OUT && !out_ready) ? OUT :
               (|req_valid) ? CONV : IDLE;
  always_comb begin
    grant = !rst && (|req_valid) && (state == IDLE || (state == OUT && out_ready));
    req_ready = grant ? (NREQ'(1) << win) : '0;
    out_valid = !rst && state == OUT;
  end
  assign cvt_flt = op;
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      op <= '0;
      id <= '0;
      out_idx <= '0;
      out_id <= '0;
    end else begin
      if (grant) begin
        op <= req_flt[32*int'(win) +: 32];
        id <= win;
        p <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
      end
      if (state == CONV) begin
        out_idx <= cvt_idx;
        out_id <= id;
      end
    end
  end
`ifdef FLT2FIX_ARB_NEG_EN
  always_ff @(posedge clk)
    if (rst) out_neg <= 1'b0;
    else if (state == CONV) out_neg <= op[31];
`endif
endmodule

// File: tb/tb_flt2fix_arb.sv
// tb_flt2fix_arb: table vectors, directed corner sequences and random traffic
// checked every cycle against a transaction-level queue model.
module tb_flt2fix_arb;
  localparam int N = 4;
  logic clk, rst, out_valid, out_ready;
  logic [N-1:0] req_valid, req_ready;
  logic [32*N-1:0] req_flt;
  logic [31:0] cvt_flt;
  logic [6:0] cvt_idx, out_idx;
  logic [1:0] out_id;
`ifdef FLT2FIX_ARB_NEG_EN
  logic out_neg;
`endif

  flt2fix_arb #(.NREQ(N), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flt(req_flt),
    .req_ready(req_ready), .cvt_flt(cvt_flt), .cvt_idx(cvt_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_id(out_id)
`ifdef FLT2FIX_ARB_NEG_EN
    , .out_neg(out_neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external converter: index = floor(|x| * 16) saturated to 0..127
  function automatic logic [6:0] conv(logic [31:0] f);
    int e;
    logic [31:0] m;
    e = int'(f[30:23]);
    m = {9'd1, f[22:0]};
    if (e < 123) return 7'd0;
    if (e > 129) return 7'd127;
    return 7'((m << (e - 123)) >> 23);
  endfunction
  assign cvt_idx = conv(cvt_flt);

  typedef struct {logic [6:0] idx; int id; bit neg; int due;} res_t;
  typedef struct {int r; logic [31:0] flt; logic [6:0] idx;} vec_t;
  res_t q[$];
  int glog[$], gcyc[$];
  int total = 0, bad = 0, cyc = 0, pp = 0;
  bit pend[N];
  logic [31:0] pflt[N];
  bit ordy, rrst;
  logic [N-1:0] s_rr;
  logic s_ov, s_neg;
  logic [6:0] s_idx;
  logic [1:0] s_id;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++) begin
      int j = (ptr + k) % N;
      if (((v >> j) & N'(1)) != 0) return j;
    end
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0] v, er;
    bit g, ov;
    int w;
    @(negedge clk);
    rst = rrst;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_flt[32*i +: 32] = pflt[i];
    end
    #1;
    v = req_valid;
    ov = !rrst && q.size() > 0 && cyc >= q[0].due;
    g = !rrst && v != 0 && (q.size() == 0 || (ov && ordy));
    w = pick(v, pp);
    er = g ? (N'(1) << w) : '0;
    s_rr = req_ready; s_ov = out_valid; s_idx = out_idx; s_id = out_id; s_neg = 1'b0;
`ifdef FLT2FIX_ARB_NEG_EN
    s_neg = out_neg;
`endif
    chk("req_ready", 32'(s_rr), 32'(er));
    chk("out_valid", 32'(s_ov), 32'(ov));
    if (ov) begin
      chk("out_idx", 32'(s_idx), 32'(q[0].idx));
      chk("out_id", 32'(s_id), 32'(q[0].id));
`ifdef FLT2FIX_ARB_NEG_EN
      chk("out_neg", 32'(s_neg), 32'(q[0].neg));
`endif
    end
    if (rrst) begin
      q.delete();
      pp = 0;
    end else begin
      if (ov && ordy) void'(q.pop_front());
      if (g) begin
        q.push_back('{conv(pflt[w]), w, pflt[w][31], cyc + 2});
        pp = (w + 1) % N;
        pend[w] = 1'b0;
        glog.push_back(w);
        gcyc.push_back(cyc);
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rrst = 1'b1;
    cycle();
    cycle();
    rrst = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  vec_t tbl[8];
  logic ovs;

  initial begin
    tbl[0] = '{0, 32'h3F800000, 7'd16};
    tbl[1] = '{1, 32'h40000000, 7'd32};
    tbl[2] = '{2, 32'h3F000000, 7'd8};
    tbl[3] = '{3, 32'h00000000, 7'd0};
    tbl[4] = '{0, 32'h42FE0000, 7'd127};
    tbl[5] = '{1, 32'h40400000, 7'd48};
    tbl[6] = '{2, 32'h3D800000, 7'd1};
    tbl[7] = '{3, 32'hBF800000, 7'd16};
    rst = 1'b1; out_ready = 1'b0; req_valid = '0; req_flt = '0;
    ordy = 1'b1; rrst = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pflt[i] = '0; end
    do_reset();
    chk("reset out_idx", 32'(out_idx), 0);
    chk("reset out_id", 32'(out_id), 0);
    // single request, latency 2
    pend[0] = 1'b1; pflt[0] = 32'h3F800000;
    cycle(); chk("single grant", 32'(s_rr), 32'h1);
    cycle(); chk("single t+1 valid", 32'(s_ov), 0);
    cycle(); chk("single t+2 valid", 32'(s_ov), 1);
    chk("single idx", 32'(s_idx), 16);
    chk("single id", 32'(s_id), 0);
    // vector table
    foreach (tbl[k]) begin
      pend[tbl[k].r] = 1'b1; pflt[tbl[k].r] = tbl[k].flt;
      idle(3);
      chk("tbl valid", 32'(s_ov), 1);
      chk("tbl idx", 32'(s_idx), 32'(tbl[k].idx));
      chk("tbl id", 32'(s_id), 32'(tbl[k].r));
`ifdef FLT2FIX_ARB_NEG_EN
      chk("tbl neg", 32'(s_neg), 32'(tbl[k].flt[31]));
`endif
    end
    // contention: all four held, 8 results
    do_reset();
    glog.delete(); gcyc.delete();
    for (int b = 0; b < 40 && glog.size() < 8; b++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin pend[i] = 1'b1; pflt[i] = {1'b0, 8'(122 + i), 23'($urandom)}; end
      cycle();
    end
    chk("contention count", 32'(glog.size()), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) begin
      chk("contention order", 32'(glog[k]), 32'(k % N));
      if (k > 0) chk("contention spacing", 32'(gcyc[k] - gcyc[k-1]), 2);
    end
    // backpressure
    do_reset();
    ordy = 1'b0;
    pend[0] = 1'b1; pflt[0] = 32'h3F800000;
    idle(2);
    pend[1] = 1'b1; pflt[1] = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp ready", 32'(s_rr), 0);
      chk("bp idx", 32'(s_idx), 16);
      chk("bp id", 32'(s_id), 0);
    end
    ordy = 1'b1;
    cycle(); chk("bp release grant", 32'(s_rr), 32'h2);
    idle(3);
    // pointer wrap: grant 2 leaves P = 3
    do_reset();
    pend[2] = 1'b1; pflt[2] = 32'h3F800000;
    idle(3);
    glog.delete();
    pend[0] = 1'b1; pflt[0] = 32'h40000000;
    pend[2] = 1'b1; pflt[2] = 32'h3F000000;
    for (int b = 0; b < 10 && glog.size() < 2; b++) cycle();
    chk("wrap count", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("wrap first", 32'(glog[0]), 0);
      chk("wrap second", 32'(glog[1]), 2);
    end
    idle(3);
    // reset while converting
    pend[0] = 1'b1; pflt[0] = 32'h40000000;
    cycle();
    rrst = 1'b1; cycle(); rrst = 1'b0;
    ovs = 1'b0;
    for (int i = 0; i < 4; i++) begin cycle(); ovs |= s_ov; end
    chk("midop no result", 32'(ovs), 0);
    chk("midop out_idx", 32'(s_idx), 0);
    chk("midop out_id", 32'(s_id), 0);
    glog.delete();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pflt[i] = 32'h3F800000; end
    cycle();
    chk("midop pointer", 32'(glog.size() > 0 ? glog[0] : -1), 0);
    // random traffic including drops and resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pflt[i] = {1'($urandom), 8'(120 + $urandom_range(0, 12)), 23'($urandom)};
        end else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      ordy = $urandom_range(0, 9) < 7;
      rrst = $urandom_range(0, 63) == 0;
      cycle();
    end
    rrst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
